// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and mult/div sequencing controller.
// Drives latch write enables, flushes and a stall-cycle counter.
module pipeline_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_is_load,
  input  logic [4:0]  dx_rd,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_uses_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        md_ready,
  output logic        pc_wren,
  output logic        fd_wren,
  output logic        dx_wren,
  output logic        xm_wren,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        md_go,
  output logic        md_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    MD_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_q, stall_d;
  logic        lu;

  assign lu = dx_is_load & (dx_rd != 5'd0) &
              ((dx_rd == fd_rs) |
               (fd_uses_rt & (dx_rd == fd_rt)));

  assign md_timeout = timeout_q;
  assign stall_cnt  = stall_q;

  // Next state and per-cycle pipeline control
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    pc_wren   = 1'b0;
    fd_wren   = 1'b0;
    dx_wren   = 1'b0;
    xm_wren   = 1'b0;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    md_go     = 1'b0;
    unique case (state_q)
      RUN: begin
        pc_wren = 1'b1;
        fd_wren = 1'b1;
        dx_wren = 1'b1;
        xm_wren = 1'b1;
        if (branch_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (md_start) begin
          md_go   = 1'b1;
          pc_wren = 1'b0;
          fd_wren = 1'b0;
          dx_wren = 1'b0;
          xm_wren = 1'b0;
          state_d = MD_WAIT;
          wcnt_d  = 6'd0;
        end else if (lu) begin
          pc_wren  = 1'b0;
          fd_wren  = 1'b0;
          dx_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        wcnt_d = wcnt_q + 6'd1;
        if (md_ready) begin
          state_d = MD_DONE;
        end else if (wcnt_q == 6'd63) begin
          timeout_d = 1'b1;
          state_d   = MD_DONE;
        end
      end
      MD_DONE: begin
        pc_wren = 1'b1;
        fd_wren = 1'b1;
        dx_wren = 1'b1;
        xm_wren = 1'b1;
        state_d = RUN;
        if (branch_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (lu) begin
          pc_wren  = 1'b0;
          fd_wren  = 1'b0;
          dx_flush = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      pc_wren  = 1'b0;
      fd_wren  = 1'b0;
      dx_wren  = 1'b0;
      xm_wren  = 1'b0;
      fd_flush = 1'b0;
      dx_flush = 1'b0;
      md_go    = 1'b0;
    end
  end

  // Saturating count of cycles where the PC is held
  always_comb begin
    stall_d = stall_q;
    if (!pc_wren && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wcnt_q    <= 6'd0;
      timeout_q <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

endmodule
